// File: rtl/cordic_angle_reduce.sv
// Range reduction ahead of a CORDIC rotator: wraps a Q4.27 angle into (-pi, pi],
// then folds it into [-pi/2, pi/2] and flags when the result must be negated.
module cordic_angle_reduce #(
  parameter int Q4_27_BITS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [Q4_27_BITS-1:0] angle_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [Q4_27_BITS-1:0] angle_out,
  output logic                         negate
);

  localparam logic signed [Q4_27_BITS-1:0] PI     = Q4_27_BITS'(32'sh1921fb54);
  localparam logic signed [Q4_27_BITS-1:0] PI_O2  = Q4_27_BITS'(32'sh0c90fdaa);
  localparam logic signed [Q4_27_BITS-1:0] TWO_PI = Q4_27_BITS'(32'sh3243f6a8);

  typedef enum logic [1:0] {IDLE, WRAP, FOLD, DONE} state_t;

  state_t                         state, state_next;
  logic signed [Q4_27_BITS-1:0]   acc, acc_next;
  logic                           negate_next;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, matching the hardware it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      acc    <= '0;
      negate <= 1'b0;
    end else begin
      state  <= state_next;
      acc    <= acc_next;
      negate <= negate_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    negate_next = negate;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          acc_next    = angle_in;
          negate_next = 1'b0;
          state_next  = WRAP;
        end
      end
      WRAP: begin
        if (acc > PI) begin
          acc_next = acc - TWO_PI;
        end else if (acc <= -PI) begin
          acc_next = acc + TWO_PI;
        end else begin
          state_next = FOLD;
        end
      end
      FOLD: begin
        // Folding by pi flips the sign of both cos and sin.
        if (acc > PI_O2) begin
          acc_next    = acc - PI;
          negate_next = 1'b1;
        end else if (acc < -PI_O2) begin
          acc_next    = acc + PI;
          negate_next = 1'b1;
        end else begin
          negate_next = 1'b0;
        end
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign angle_out = acc;

endmodule

// File: tb/tb_cordic_angle_reduce.sv
// Scoreboard bench for cordic_angle_reduce: a driver pushes model results,
// a negedge monitor pops and compares whenever out_valid is presented.
module tb_cordic_angle_reduce;

  localparam longint P   = 64'sd421657428;
  localparam longint PO2 = 64'sd210828714;
  localparam longint T   = 64'sd843314856;
  localparam longint LO  = -64'sd843314856;
  localparam real    LSB = 1.0 / 134217728.0;

  typedef struct {
    logic signed [31:0] x;
    logic signed [31:0] angle;
    logic               neg;
    int                 lat;
    longint             cap;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] angle_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [31:0] angle_out;
  logic               negate;

  int     tests = 0;
  int     failed = 0;
  longint cycle = 0;
  int     ready_mode = 0;
  exp_t   sb[$];

  cordic_angle_reduce #(.Q4_27_BITS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .angle_in(angle_in), .out_valid(out_valid), .out_ready(out_ready),
    .angle_out(angle_out), .negate(negate)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input bit ok, input string detail);
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic real fabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Reference: pick the integer n that places x - n*2pi in (-pi, pi], then fold.
  function automatic exp_t model(input logic signed [31:0] x);
    exp_t   e;
    longint a, num, n, r;
    a   = longint'(x);
    num = a - P;
    n   = num / T;
    if (n * T < num) n++;
    r = a - n * T;
    e.neg = 1'b0;
    if (r > PO2) begin
      r = r - P; e.neg = 1'b1;
    end else if (r < -PO2) begin
      r = r + P; e.neg = 1'b1;
    end
    e.x     = x;
    e.angle = 32'(r);
    e.lat   = int'((n < 0) ? -n : n) + 2;
    e.cap   = 0;
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0)      out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'b0;
      else                      out_ready = 1'($urandom_range(1, 0));
    end
  end

  // Monitor
  bit                 holding = 0, after_xfer = 0;
  logic signed [31:0] held_a;
  logic               held_n;
  always @(negedge clk) begin
    exp_t e;
    real  ai, ao, sg;
    if (!rst) begin
      holding = 0; after_xfer = 0;
    end else begin
      if (after_xfer)
        check("idle_after_xfer", !out_valid && in_ready,
              $sformatf("out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready));
      after_xfer = 0;
      if (out_valid) begin
        check("in_ready_in_done", !in_ready, $sformatf("in_ready=%0b want 0", in_ready));
        if (holding) begin
          check("hold_stable", angle_out == held_a && negate == held_n,
                $sformatf("got %h/%0b want %h/%0b", angle_out, negate, held_a, held_n));
        end else begin
          check("unexpected_out", sb.size() > 0,
                $sformatf("out_valid with empty scoreboard, angle_out=%h", angle_out));
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("angle", angle_out == e.angle,
                  $sformatf("in=%h got %h want %h", e.x, angle_out, e.angle));
            check("negate", negate == e.neg,
                  $sformatf("in=%h got %0b want %0b", e.x, negate, e.neg));
            check("latency", cycle - e.cap == longint'(e.lat),
                  $sformatf("in=%h got %0d want %0d", e.x, cycle - e.cap, e.lat));
            check("range", longint'(angle_out) >= -PO2 && longint'(angle_out) <= PO2,
                  $sformatf("in=%h angle_out=%h outside [-pi/2,pi/2]", e.x, angle_out));
            ai = $itor(e.x) * LSB;
            ao = $itor(angle_out) * LSB;
            sg = negate ? -1.0 : 1.0;
            check("trig", (fabs($cos(ai) - sg * $cos(ao)) <= 2.0 * LSB + 1e-12) &&
                          (fabs($sin(ai) - sg * $sin(ao)) <= 2.0 * LSB + 1e-12),
                  $sformatf("in=%h got %h neg=%0b: cos/sin differ beyond 2 LSB", e.x, angle_out, negate));
          end
        end
        holding = !out_ready;
        held_a  = angle_out;
        held_n  = negate;
        if (out_ready) after_xfer = 1;
      end
    end
  end

  task automatic send(input logic signed [31:0] x, input bit expect_out);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    angle_in = x;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("accept_timeout", 1'b0 == in_ready, $sformatf("in_ready stuck low for %h", x));
    @(posedge clk); #1;
    in_valid = 1'b0;
    angle_in = $urandom;
    if (expect_out) begin
      e     = model(x);
      e.cap = cycle;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size() == 0 && !out_valid,
          $sformatf("pending=%0d out_valid=%0b after %0d cycles", sb.size(), out_valid, n));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_state", !out_valid && in_ready && angle_out == 0 && !negate,
          $sformatf("out_valid=%0b in_ready=%0b angle_out=%h negate=%0b want 0/1/0/0",
                    out_valid, in_ready, angle_out, negate));
    rst = 1'b1;

    send(32'sh6487ed51, 1);
    send(32'sh12d97c7f, 1);
    send(32'she6de04ac, 1);
    send(32'sh0c90fdaa, 1);
    send(32'shf36f0256, 1);
    send(32'sh1921fb54, 1);
    drain();

    // Back-pressure: result must hold while in_valid pulses are ignored.
    @(negedge clk); ready_mode = 1;
    send(32'sh12d97c7f, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_reach_done", out_valid, $sformatf("out_valid=%0b want 1", out_valid));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      angle_in = $urandom;
      @(negedge clk);
      check("bp_hold", out_valid && !in_ready,
            $sformatf("cycle %0d out_valid=%0b in_ready=%0b want 1/0", i, out_valid, in_ready));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); ready_mode = 0;
    drain();

    // Reset mid-WRAP aborts the request.
    send(32'sh7fffffff, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_reset", !out_valid && in_ready && angle_out == 0 && !negate,
          $sformatf("out_valid=%0b in_ready=%0b angle_out=%h negate=%0b want 0/1/0/0",
                    out_valid, in_ready, angle_out, negate));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_output", !out_valid && in_ready,
          $sformatf("out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready));
    send(32'sh00000000, 1);
    drain();

    // Random sweep with random downstream stalls.
    @(negedge clk); ready_mode = 2;
    for (int i = 0; i < 150; i++)
      send(32'(LO + longint'($urandom_range(32'd2529944569, 0))), 1);
    for (int i = 0; i < 30; i++)
      send($urandom, 1);
    drain();
    @(negedge clk); ready_mode = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cordic_angle_reduce.md
CORDIC_ANGLE_REDUCE -- requirements
Module: cordic_angle_reduce

Interface
REQ-001 Parameter: Q4_27_BITS, default 32, angle width in Q4.27 signed (1 sign, 4 integer, 27 fractional bits).
REQ-002 Constant: PI = 32'sh1921fb54, PI_O2 = 32'sh0c90fdaa, TWO_PI = 32'sh3243f6a8, all Q4.27.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  angle_in holds a valid request.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 angle_in  input  Q4_27_BITS  signed Q4.27 angle, any representable value; nominal range [-2pi, 4pi].
REQ-008 out_valid  output  1  angle_out and negate are valid.
REQ-009 out_ready  input  1  downstream CORDIC accepts the result.
REQ-010 angle_out  output  Q4_27_BITS  signed Q4.27 reduced angle in [-pi/2, pi/2].
REQ-011 negate  output  1  downstream negates both cosine and sine (angle folded by pi).

Function
REQ-012 FSM states: IDLE, WRAP, FOLD, DONE; one state active at a time.
REQ-013 IDLE: in_ready = 1, out_valid = 0; on in_valid = 1, latch angle_in into accumulator a, clear negate, go to WRAP.
REQ-014 WRAP, one action per cycle: if a > PI, a <= a - TWO_PI; else if a <= -PI, a <= a + TWO_PI; else go to FOLD with a unchanged.
REQ-015 WRAP exit range: a in (-PI, PI]; full 32-bit input range needs at most 3 wrap cycles, and no intermediate value overflows.
REQ-016 FOLD, one cycle: if a > PI_O2, a <= a - PI and negate <= 1; else if a < -PI_O2, a <= a + PI and negate <= 1; else unchanged, negate <= 0; go to DONE.
REQ-017 Boundaries: a == PI_O2 and a == -PI_O2 are not folded; a == PI folds to 0 with negate = 1.
REQ-018 DONE: out_valid = 1, in_ready = 0; angle_out = a, stable while out_valid = 1 and out_ready = 0.
REQ-019 DONE with out_ready = 1: transfer completes on that edge; go to IDLE. No new request is accepted in the same cycle.
REQ-020 Latency: angle_in capture edge to first out_valid cycle = k + 2 cycles, where k = number of wrap corrections (0..3).
REQ-021 in_ready = 1 only in IDLE; in_valid outside IDLE is ignored and angle_in is not sampled.
REQ-022 Arithmetic: all adds and subtracts are full Q4_27_BITS signed, with no rounding or saturation; the result is exact modulo the constants.
REQ-023 Outputs are registered; angle_out = a register and negate = negate register, with no combinational path from inputs to outputs.

Reset
REQ-024 rst = 0 forces, asynchronously: state = IDLE, a = 0, negate = 0, out_valid = 0, in_ready = 1 (once rst releases).
REQ-025 Reset asserted in WRAP, FOLD or DONE aborts the operation; no out_valid is produced for the aborted request.
REQ-026 After rst deasserts, the first accepted request behaves identically to one accepted after power-up.

Verification
REQ-027 angle_in = 32'sh6487ed51 (4pi), out_ready = 1 -> angle_out = 32'sh00000001, negate = 0, out_valid 4 cycles after capture (k = 2).
REQ-028 angle_in = 32'sh12d97c7f (3pi/4) -> angle_out = 32'shf9b7812b (-pi/4), negate = 1, latency 2.
REQ-029 angle_in = 32'she6de04ac (-pi) -> wrap to 32'sh1921fb54, fold -> angle_out = 0, negate = 1, latency 3; angle_in = 32'sh0c90fdaa (pi/2) -> unchanged, negate = 0.
REQ-030 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, angle_out/negate stable, in_ready = 0, in_valid pulses ignored; out_ready = 1 -> IDLE next cycle.
REQ-031 rst pulsed low during WRAP for angle_in = 32'sh7fffffff -> out_valid never asserts for it; outputs at reset values; the next request (0) -> angle_out = 0, negate = 0, latency 2.
REQ-032 Random sweep over [-2pi, 4pi] -> angle_out within [-PI_O2, PI_O2] and (-1)^negate * (cos, sin)(angle_out) matches the reference model for angle_in within 2 LSB.
